// File: rtl/aes_channel_arbiter.sv
// aes_channel_arbiter
//   Shares one aes_encryptor core between NUM_CH channels. A grant covers a
//   whole message: key/sync load, input stream, and output drain. Channels are
//   served round-robin starting after the last channel that completed (or was
//   aborted). Messages never interleave.
//
// Ports
//   clk, rst                       clock, synchronous active-high reset
//   ch_key_valid/key/sync/key_rdy  per-channel key request; key_rdy pulses on accept
//   ch_in_*                        per-channel avalon_st input, ch_in_rdy gated to grant
//   ch_out_*                       core output broadcast; ch_out_valid gated to grant
//   core_key_*, core_in_*, core_out_*  shared core interface
//   grant_id, busy                 current grant (0 when idle), non-idle flag
//   timeout_err                    1-cycle pulse when the stall watchdog aborts a message
//
// Optional feature
//   ARB_TIMEOUT_EN : enables a 16-bit stall watchdog (TIMEOUT_CYCLES). When it
//   is not defined the arbiter waits indefinitely and timeout_err is tied low.

module aes_channel_arbiter_lane (
  input  logic sel,
  input  logic key_ph,
  input  logic in_ph,
  input  logic out_ph,
  input  logic core_key_rdy,
  input  logic core_in_rdy,
  input  logic core_out_valid,
  output logic key_rdy,
  output logic in_rdy,
  output logic out_valid
);
  assign key_rdy   = sel & key_ph & core_key_rdy;
  assign in_rdy    = sel & in_ph  & core_in_rdy;
  assign out_valid = sel & out_ph & core_out_valid;
endmodule

module aes_channel_arbiter #(
  parameter int NUM_CH         = 4,
  parameter int DATA_W         = 128,
  parameter int EMPTY_W        = 4,
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int GW            = $clog2(NUM_CH)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_CH-1:0]           ch_key_valid,
  input  logic [NUM_CH*DATA_W-1:0]    ch_key,
  input  logic [NUM_CH*DATA_W-1:0]    ch_sync,
  output logic [NUM_CH-1:0]           ch_key_rdy,
  input  logic [NUM_CH-1:0]           ch_in_valid,
  input  logic [NUM_CH-1:0]           ch_in_sop,
  input  logic [NUM_CH-1:0]           ch_in_eop,
  input  logic [NUM_CH*DATA_W-1:0]    ch_in_data,
  input  logic [NUM_CH*EMPTY_W-1:0]   ch_in_empty,
  output logic [NUM_CH-1:0]           ch_in_rdy,
  output logic                        core_key_valid,
  output logic [DATA_W-1:0]           core_key,
  output logic [DATA_W-1:0]           core_sync,
  input  logic                        core_key_rdy,
  output logic                        core_in_valid,
  output logic                        core_in_sop,
  output logic                        core_in_eop,
  output logic [DATA_W-1:0]           core_in_data,
  output logic [EMPTY_W-1:0]          core_in_empty,
  input  logic                        core_in_rdy,
  input  logic                        core_out_valid,
  input  logic                        core_out_sop,
  input  logic                        core_out_eop,
  input  logic [DATA_W-1:0]           core_out_data,
  input  logic [EMPTY_W-1:0]          core_out_empty,
  output logic                        core_out_rdy,
  output logic [NUM_CH-1:0]           ch_out_valid,
  output logic [DATA_W-1:0]           ch_out_data,
  output logic                        ch_out_sop,
  output logic                        ch_out_eop,
  output logic [EMPTY_W-1:0]          ch_out_empty,
  input  logic [NUM_CH-1:0]           ch_out_rdy,
  output logic [GW-1:0]               grant_id,
  output logic                        busy,
  output logic                        timeout_err
);

  typedef enum logic [1:0] {IDLE, LOAD_KEY, STREAM, DRAIN} state_t;

  state_t          state, state_nxt;
  logic [GW-1:0]   gid, gid_nxt;
  logic [GW-1:0]   last_grant, last_nxt;

  // round-robin search
  logic            rr_found;
  logic [GW-1:0]   rr_win;
  logic [GW:0]     rr_idx;

  // granted-channel slice
  logic [DATA_W-1:0]  sel_key, sel_sync, sel_in_data;
  logic [EMPTY_W-1:0] sel_in_empty;
  logic               sel_in_valid, sel_in_sop, sel_in_eop, sel_out_rdy;

  logic key_ph, in_ph, out_ph;
  logic in_hs, out_hs, in_eop_hs, out_eop_hs;
  logic stall_abort;

  assign key_ph = (state == LOAD_KEY);
  assign in_ph  = (state == STREAM);
  assign out_ph = (state == STREAM) || (state == DRAIN);

  // First requester strictly after last_grant, wrapping; works for any NUM_CH.
  always_comb begin
    rr_found = 1'b0;
    rr_win   = '0;
    rr_idx   = '0;
    for (int off = 1; off <= NUM_CH; off++) begin
      rr_idx = {1'b0, last_grant} + (GW+1)'(off);
      if (rr_idx >= (GW+1)'(NUM_CH)) rr_idx = rr_idx - (GW+1)'(NUM_CH);
      if (!rr_found && ch_key_valid[rr_idx[GW-1:0]]) begin
        rr_found = 1'b1;
        rr_win   = rr_idx[GW-1:0];
      end
    end
  end

  always_comb begin
    sel_key      = '0;
    sel_sync     = '0;
    sel_in_data  = '0;
    sel_in_empty = '0;
    sel_in_valid = 1'b0;
    sel_in_sop   = 1'b0;
    sel_in_eop   = 1'b0;
    sel_out_rdy  = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (gid == GW'(i)) begin
        sel_key      = ch_key[i*DATA_W +: DATA_W];
        sel_sync     = ch_sync[i*DATA_W +: DATA_W];
        sel_in_data  = ch_in_data[i*DATA_W +: DATA_W];
        sel_in_empty = ch_in_empty[i*EMPTY_W +: EMPTY_W];
        sel_in_valid = ch_in_valid[i];
        sel_in_sop   = ch_in_sop[i];
        sel_in_eop   = ch_in_eop[i];
        sel_out_rdy  = ch_out_rdy[i];
      end
    end
  end

  // Core-facing side: zero-latency mux, forced quiet outside its phase.
  assign core_key_valid = key_ph;
  assign core_key       = key_ph ? sel_key  : '0;
  assign core_sync      = key_ph ? sel_sync : '0;
  assign core_in_valid  = in_ph & sel_in_valid;
  assign core_in_sop    = in_ph & sel_in_sop;
  assign core_in_eop    = in_ph & sel_in_eop;
  assign core_in_data   = in_ph ? sel_in_data  : '0;
  assign core_in_empty  = in_ph ? sel_in_empty : '0;
  assign core_out_rdy   = out_ph & sel_out_rdy;

  // Output payload is broadcast; only ch_out_valid is qualified per channel.
  assign ch_out_data  = core_out_data;
  assign ch_out_sop   = core_out_sop;
  assign ch_out_eop   = core_out_eop;
  assign ch_out_empty = core_out_empty;

  assign busy     = (state != IDLE);
  assign grant_id = busy ? gid : '0;

  assign in_hs      = core_in_valid & core_in_rdy;
  assign out_hs     = core_out_valid & core_out_rdy;
  assign in_eop_hs  = in_hs & core_in_eop;
  assign out_eop_hs = out_hs & core_out_eop;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
    aes_channel_arbiter_lane u_lane (
      .sel            (gid == GW'(i)),
      .key_ph         (key_ph),
      .in_ph          (in_ph),
      .out_ph         (out_ph),
      .core_key_rdy   (core_key_rdy),
      .core_in_rdy    (core_in_rdy),
      .core_out_valid (core_out_valid),
      .key_rdy        (ch_key_rdy[i]),
      .in_rdy         (ch_in_rdy[i]),
      .out_valid      (ch_out_valid[i])
    );
  end

`ifdef ARB_TIMEOUT_EN
  logic [15:0] stall_cnt;
  logic        timeout_q;

  // Abort fires on the TIMEOUT_CYCLES-th consecutive cycle without a handshake.
  assign stall_abort = out_ph && !(in_hs || out_hs) &&
                       (stall_cnt == 16'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst || !out_ph || in_hs || out_hs) stall_cnt <= '0;
    else                                   stall_cnt <= stall_cnt + 16'd1;
    timeout_q <= rst ? 1'b0 : stall_abort;
  end

  assign timeout_err = timeout_q;
`else
  assign stall_abort = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    gid_nxt   = gid;
    last_nxt  = last_grant;
    case (state)
      IDLE: begin
        if (rr_found) begin
          gid_nxt   = rr_win;
          state_nxt = LOAD_KEY;
        end
      end
      LOAD_KEY: begin
        // grant is held even if ch_key_valid drops here
        if (core_key_rdy) state_nxt = STREAM;
      end
      STREAM: begin
        if (in_eop_hs) begin
          if (out_eop_hs) begin
            state_nxt = IDLE;
            last_nxt  = gid;
          end else begin
            state_nxt = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (out_eop_hs) begin
          state_nxt = IDLE;
          last_nxt  = gid;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (stall_abort) begin
      state_nxt = IDLE;
      last_nxt  = gid;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      gid        <= '0;
      last_grant <= GW'(NUM_CH - 1);
    end else begin
      state      <= state_nxt;
      gid        <= gid_nxt;
      last_grant <= last_nxt;
    end
  end

endmodule

// File: tb/tb_aes_channel_arbiter.sv
// Randomized bench for aes_channel_arbiter with a behavioural model of the
// channels, the core (fixed-latency XOR-with-key pipe) and the round-robin rule.
module tb_aes_channel_arbiter;
  localparam int NUM_CH = 4;
  localparam int DW     = 32;
  localparam int EW     = 4;
  localparam int GW     = 2;
  localparam int TO     = 32;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [NUM_CH-1:0]      ch_key_valid, ch_key_rdy;
  logic [NUM_CH*DW-1:0]   ch_key, ch_sync, ch_in_data;
  logic [NUM_CH-1:0]      ch_in_valid, ch_in_sop, ch_in_eop, ch_in_rdy;
  logic [NUM_CH*EW-1:0]   ch_in_empty;
  logic                   core_key_valid, core_key_rdy;
  logic [DW-1:0]          core_key, core_sync;
  logic                   core_in_valid, core_in_sop, core_in_eop, core_in_rdy;
  logic [DW-1:0]          core_in_data;
  logic [EW-1:0]          core_in_empty;
  logic                   core_out_valid, core_out_sop, core_out_eop, core_out_rdy;
  logic [DW-1:0]          core_out_data;
  logic [EW-1:0]          core_out_empty;
  logic [NUM_CH-1:0]      ch_out_valid, ch_out_rdy;
  logic [DW-1:0]          ch_out_data;
  logic                   ch_out_sop, ch_out_eop;
  logic [EW-1:0]          ch_out_empty;
  logic [GW-1:0]          grant_id;
  logic                   busy, timeout_err;

  aes_channel_arbiter #(.NUM_CH(NUM_CH), .DATA_W(DW), .EMPTY_W(EW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .ch_key_valid(ch_key_valid), .ch_key(ch_key), .ch_sync(ch_sync), .ch_key_rdy(ch_key_rdy),
    .ch_in_valid(ch_in_valid), .ch_in_sop(ch_in_sop), .ch_in_eop(ch_in_eop),
    .ch_in_data(ch_in_data), .ch_in_empty(ch_in_empty), .ch_in_rdy(ch_in_rdy),
    .core_key_valid(core_key_valid), .core_key(core_key), .core_sync(core_sync),
    .core_key_rdy(core_key_rdy),
    .core_in_valid(core_in_valid), .core_in_sop(core_in_sop), .core_in_eop(core_in_eop),
    .core_in_data(core_in_data), .core_in_empty(core_in_empty), .core_in_rdy(core_in_rdy),
    .core_out_valid(core_out_valid), .core_out_sop(core_out_sop), .core_out_eop(core_out_eop),
    .core_out_data(core_out_data), .core_out_empty(core_out_empty), .core_out_rdy(core_out_rdy),
    .ch_out_valid(ch_out_valid), .ch_out_data(ch_out_data), .ch_out_sop(ch_out_sop),
    .ch_out_eop(ch_out_eop), .ch_out_empty(ch_out_empty), .ch_out_rdy(ch_out_rdy),
    .grant_id(grant_id), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1);
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic [DW-1:0]      key;
    logic [DW-1:0]      sync;
    logic [EW-1:0]      empty;
    logic [2:0]         nb;
    logic [3:0][DW-1:0] d;
  } msg_t;

  // channel model
  msg_t cur [NUM_CH];
  int   ch_st [NUM_CH];     // 0 requesting, 1 streaming, 3 finished
  int   beat [NUM_CH];
  int   msgs_left [NUM_CH];
  int   nb_cfg;
  // arbiter model
  int   m_phase;            // 0 idle, 1 key, 2 stream, 3 drain
  int   cur_g;
  int   model_last;
  int   gq[$];
  // core model
  logic [DW-1:0]        core_key_m;
  logic [EW+DW+1:0]     core_q[$];
  int                   core_t[$];
  logic [DW:0]          exp_q[$];
  int   cyc = 0;
  int   lat = 4;
  bit   full = 1'b0;
  int   n_in_hs;

  function automatic msg_t mk_msg(input int nb);
    msg_t m;
    m.key   = $urandom;
    m.sync  = $urandom;
    m.empty = EW'($urandom_range(0, 15));
    m.nb    = 3'((nb == 0) ? $urandom_range(1, 4) : nb);
    for (int k = 0; k < 4; k++) m.d[k] = $urandom;
    return m;
  endfunction

  function automatic int rr_pick(input int last, input logic [NUM_CH-1:0] req);
    logic [NUM_CH-1:0] r;
    for (int off = 1; off <= NUM_CH; off++) begin
      r = req >> ((last + off) % NUM_CH);
      if (r[0]) return (last + off) % NUM_CH;
    end
    return -1;
  endfunction

  task automatic clear_inputs();
    ch_key_valid = '0; ch_key = '0; ch_sync = '0;
    ch_in_valid = '0; ch_in_sop = '0; ch_in_eop = '0; ch_in_data = '0; ch_in_empty = '0;
    ch_out_rdy = '0; core_key_rdy = 1'b0; core_in_rdy = 1'b0;
    core_out_valid = 1'b0; core_out_sop = 1'b0; core_out_eop = 1'b0;
    core_out_data = '0; core_out_empty = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    clear_inputs();
    @(negedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_gid", grant_id, 0);
    chk("rst_terr", timeout_err, 0);
    chk("rst_vr", {ch_key_rdy, ch_in_rdy, ch_out_valid, core_key_valid, core_in_valid, core_out_rdy}, 0);
    rst = 1'b0;
    m_phase = 0; model_last = NUM_CH - 1;
    core_q.delete(); core_t.delete(); exp_q.delete();
    for (int i = 0; i < NUM_CH; i++) ch_st[i] = 3;
  endtask

  task automatic setup(input logic [NUM_CH-1:0] en, input int nmsg, input int nb,
                       input int l, input bit f);
    nb_cfg = nb; lat = l; full = f; n_in_hs = 0;
    gq.delete();
    for (int i = 0; i < NUM_CH; i++) begin
      msgs_left[i] = en[i] ? nmsg : 0;
      ch_st[i]     = en[i] ? 0 : 3;
      beat[i]      = 0;
      if (en[i]) cur[i] = mk_msg(nb);
    end
  endtask

  task automatic step();
    logic [NUM_CH-1:0] mask;
    logic [DW:0]       e;
    logic              in_eop, out_eop, eop_exp;
    @(negedge clk);
    cyc++;
    for (int i = 0; i < NUM_CH; i++) begin
      ch_key_valid[i]        = (ch_st[i] == 0);
      ch_key[i*DW +: DW]     = cur[i].key;
      ch_sync[i*DW +: DW]    = cur[i].sync;
      ch_in_valid[i]         = (ch_st[i] == 1) && ($urandom_range(0, 3) != 0);
      ch_in_data[i*DW +: DW] = cur[i].d[beat[i] & 3];
      ch_in_sop[i]           = (beat[i] == 0);
      ch_in_eop[i]           = (beat[i] == int'(cur[i].nb) - 1);
      ch_in_empty[i*EW +: EW] = ch_in_eop[i] ? cur[i].empty : '0;
      ch_out_rdy[i]          = ($urandom_range(0, 3) != 0);
    end
    core_key_rdy = full ? 1'b1 : 1'($urandom_range(0, 1));
    core_in_rdy  = full ? 1'b1 : ($urandom_range(0, 3) != 0);
    if (core_q.size() > 0 && core_t[0] <= cyc) begin
      core_out_valid = 1'b1;
      {core_out_sop, core_out_eop, core_out_empty, core_out_data} = core_q[0];
    end else begin
      core_out_valid = 1'b0;
      {core_out_sop, core_out_eop, core_out_empty, core_out_data} = '0;
    end
    #1;
    chk("busy", busy, m_phase != 0);
    chk("gid", grant_id, (m_phase != 0) ? cur_g : 0);
    if (m_phase == 0) begin
      chk("idle_q", {ch_key_rdy, ch_in_rdy, ch_out_valid, core_key_valid, core_in_valid, core_out_rdy}, 0);
      if (|ch_key_valid) begin
        cur_g = rr_pick(model_last, ch_key_valid);
        m_phase = 1;
        gq.push_back(cur_g);
      end
    end else begin
      mask = NUM_CH'(1) << cur_g;
      chk("excl", (ch_key_rdy | ch_in_rdy | ch_out_valid) & ~mask, 0);
      if (m_phase == 1) begin
        chk("kvld", core_key_valid, 1);
        chk("key_rdy", ch_key_rdy, core_key_rdy ? mask : '0);
        if (core_key_rdy) begin
          chk("key", core_key, cur[cur_g].key);
          chk("sync", core_sync, cur[cur_g].sync);
          core_key_m = core_key;
          for (int k = 0; k < int'(cur[cur_g].nb); k++)
            exp_q.push_back({k == int'(cur[cur_g].nb) - 1, cur[cur_g].d[k] ^ cur[cur_g].key});
          ch_st[cur_g] = 1; beat[cur_g] = 0; m_phase = 2;
        end
      end else begin
        in_eop = 1'b0; out_eop = 1'b0;
        if (m_phase == 2) begin
          chk("in_vld", core_in_valid, ch_in_valid[cur_g]);
          chk("in_rdy", ch_in_rdy[cur_g], core_in_rdy);
        end else begin
          chk("drain_in", core_in_valid, 0);
        end
        if (core_out_valid) chk("out_rdy", core_out_rdy, ch_out_rdy[cur_g]);
        chk("out_vld", ch_out_valid, core_out_valid ? mask : '0);
        if (m_phase == 2 && core_in_valid && core_in_rdy) begin
          eop_exp = (beat[cur_g] == int'(cur[cur_g].nb) - 1);
          chk("in_data", core_in_data, cur[cur_g].d[beat[cur_g]]);
          chk("in_eop", core_in_eop, eop_exp);
          chk("in_empty", core_in_empty, eop_exp ? cur[cur_g].empty : '0);
          core_q.push_back({core_in_sop, core_in_eop, core_in_empty, core_in_data ^ core_key_m});
          core_t.push_back(cyc + lat);
          n_in_hs++;
          beat[cur_g]++;
          if (eop_exp) begin
            in_eop = 1'b1;
            msgs_left[cur_g]--;
            if (msgs_left[cur_g] > 0) begin
              cur[cur_g] = mk_msg(nb_cfg);
              ch_st[cur_g] = 0;
            end else begin
              ch_st[cur_g] = 3;
            end
          end
        end
        if (core_out_valid && core_out_rdy) begin
          e = exp_q.pop_front();
          chk("out_data", ch_out_data, e[DW-1:0]);
          chk("out_eop", ch_out_eop, e[DW]);
          void'(core_q.pop_front());
          void'(core_t.pop_front());
          out_eop = e[DW];
        end
        if (m_phase == 2 && in_eop)       m_phase = out_eop ? 0 : 3;
        else if (m_phase == 3 && out_eop) m_phase = 0;
        if (m_phase == 0) model_last = cur_g;
      end
    end
  endtask

  function automatic bit all_done();
    for (int i = 0; i < NUM_CH; i++) if (ch_st[i] != 3) return 1'b0;
    return (m_phase == 0) && (exp_q.size() == 0);
  endfunction

  task automatic run(input string tag, input int max_cyc);
    int k = 0;
    while (!all_done() && k < max_cyc) begin
      step();
      k++;
    end
    chk(tag, all_done(), 1);
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    repeat (2) @(negedge clk);
    do_reset();

    // ch 0 and 2 request together: 0 first, then 2
    setup(4'b0101, 1, 2, 3, 1'b0);
    run("run_0101", 500);
    chk("o0101_n", gq.size(), 2);
    chk("o0101_0", gq[0], 0);
    chk("o0101_1", gq[1], 2);

    // ch 1, 3 beats, long core latency: input finishes, then drain
    do_reset();
    setup(4'b0010, 1, 3, 12, 1'b1);
    run("run_ch1", 500);
    chk("ch1_in_hs", n_in_hs, 3);
    chk("ch1_grant", gq[0], 1);

    // all four requesting continuously, 1-beat messages
    do_reset();
    setup(4'b1111, 2, 1, 2, 1'b0);
    run("run_all4", 1000);
    chk("o4_n", gq.size(), 8);
    chk("o4_0", gq[0], 0);
    chk("o4_1", gq[1], 1);
    chk("o4_2", gq[2], 2);
    chk("o4_3", gq[3], 3);
    chk("o4_4", gq[4], 0);

    // random traffic
    do_reset();
    setup(4'b1111, 3, 0, $urandom_range(1, 12), 1'b0);
    run("run_rand", 4000);

    // output eop in the same cycle as input eop: straight back to IDLE
    do_reset();
    @(negedge clk);
    ch_key_valid = 4'b0001; ch_key[DW-1:0] = 32'h1234_5678; core_key_rdy = 1'b1;
    #1 chk("sc_idle", busy, 0);
    @(negedge clk);
    #1 chk("sc_load", core_key_valid, 1);
    chk("sc_key", core_key, 32'h1234_5678);
    @(negedge clk);
    ch_key_valid = '0;
    ch_in_valid = 4'b0001; ch_in_sop = 4'b0001; ch_in_eop = 4'b0001; ch_in_data[DW-1:0] = 32'hCAFE_0001;
    core_in_rdy = 1'b1;
    core_out_valid = 1'b1; core_out_sop = 1'b1; core_out_eop = 1'b1; core_out_data = 32'hBEEF_0001;
    ch_out_rdy = 4'b0001;
    #1 chk("sc_in_rdy", ch_in_rdy, 4'b0001);
    chk("sc_out_vld", ch_out_valid, 4'b0001);
    chk("sc_in_data", core_in_data, 32'hCAFE_0001);
    @(negedge clk);
    clear_inputs();
    #1 chk("sc_no_drain", busy, 0);

    // reset in the middle of a ch 2 message
    do_reset();
    setup(4'b0100, 1, 4, 12, 1'b0);
    begin
      int k = 0;
      while (!(m_phase == 2 && beat[2] >= 1) && k < 300) begin
        step();
        k++;
      end
      chk("mid_reached", (m_phase == 2 && beat[2] >= 1), 1);
    end
    do_reset();
    setup(4'b1111, 1, 1, 2, 1'b0);
    run("run_post_rst", 500);
    chk("post_rst_g0", gq[0], 0);

`ifdef ARB_TIMEOUT_EN
    // stalled core input: watchdog aborts, next requester is served
    do_reset();
    @(negedge clk);
    ch_key_valid = 4'b0110; core_key_rdy = 1'b1;
    @(negedge clk);
    @(negedge clk);
    ch_key_valid = 4'b0100; ch_in_valid = 4'b0010;
    begin
      int n_busy = 0;
      int pulses = 0;
      bit seen_idle = 1'b0;
      bit te_at_idle = 1'b0;
      int g_after = -1;
      for (int k = 0; k < TO + 8; k++) begin
        #1;
        if (timeout_err) pulses++;
        if (!seen_idle) begin
          if (busy) n_busy++;
          else begin
            seen_idle = 1'b1;
            te_at_idle = timeout_err;
          end
        end else if (busy && g_after < 0) begin
          g_after = int'(grant_id);
        end
        @(negedge clk);
      end
      chk("to_cycles", n_busy, TO);
      chk("to_pulse_at_idle", te_at_idle, 1);
      chk("to_pulses", pulses, 1);
      chk("to_next_grant", g_after, 2);
    end
    clear_inputs();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
